// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
//
// N-channel to one registered multiplexer with valid/ready handshaking. The
// output stage is a single register slot. Each cycle the slot is free, at most
// one channel is granted. Which channel gets the grant depends on the mode:
//   - fixed mode (mode = 0): the channel selected by s.
//   - round-robin mode (mode = 1): the first valid channel after the last
//     round-robin winner.
// The granted word appears on out_data one cycle later. A stalled slot holds
// its word. When the slot drains and is refilled in the same cycle, the
// multiplexer sustains one word per cycle.
//
// Parameters
//   WIDTH      data bits per channel (1..64)
//   N          channel count (2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    N*WIDTH  channel k in bits [k*WIDTH +: WIDTH]
//   in_valid   N        per-channel valid
//   in_ready   N        one-hot-or-zero accept strobe (combinational)
//   s          SW       fixed-mode channel select (SW = $clog2(N))
//   mode       1        0 = fixed select, 1 = round-robin
//   out_data   WIDTH    registered selected word
//   out_valid  1        out_data valid
//   out_ready  1        downstream accept
//   out_sel    SW       source channel of out_data
//   xfer_cnt   16       completed output transfers, wraps (only present when
//                       MUX_RR_STATS_EN is defined)
//
// Build option
//   MUX_RR_STATS_EN    adds the xfer_cnt transfer counter output.
// -----------------------------------------------------------------------------
module mux_rr_reg #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SW-1:0]        s,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_sel
`ifdef MUX_RR_STATS_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SW-1:0]    out_sel_reg;
  logic [SW-1:0]    ptr_reg;

  logic [WIDTH-1:0] chan_data [N];
  logic [SW-1:0]    cand [N];      // channel index at search offset gi+1
  logic [N-1:0]     rr_hit;        // cand[gi] is valid

  logic             slot_free;
  logic             rr_found;
  logic [SW-1:0]    rr_idx;
  logic             s_in_range;
  logic             fix_hit;
  logic             grant;
  logic [SW-1:0]    grant_idx;

  // Per-channel slicing, round-robin candidates and the accept strobes.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      logic [SW:0] sum;

      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];

      // Since ptr < N and the offset is at most N, the sum stays below 2N.
      // One conditional subtract therefore gives the index modulo N.
      assign sum      = {1'b0, ptr_reg} + (SW+1)'(gi + 1);
      assign cand[gi] = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N))
                                            : sum[SW-1:0];
      assign rr_hit[gi] = in_valid[cand[gi]];

      assign in_ready[gi] = grant && (grant_idx == SW'(gi));
    end
  endgenerate

  // Round-robin pick. The scan runs from the farthest offset to the nearest,
  // so the nearest valid channel (smallest offset after ptr) is written last
  // and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_reg;
    for (int i = N - 1; i >= 0; i--) begin
      if (rr_hit[i]) begin
        rr_found = 1'b1;
        rr_idx   = cand[i];
      end
    end
  end

  // Fixed mode: when N is not a power of two, s can name a channel that does
  // not exist. Such a select grants nothing.
  assign s_in_range = ({1'b0, s} < (SW+1)'(N));
  assign fix_hit    = s_in_range && in_valid[s];

  assign slot_free = (state_reg == EMPTY) || out_ready;
  assign grant     = !rst && slot_free && (mode ? rr_found : fix_hit);
  assign grant_idx = mode ? rr_idx : s;

  // Output slot state machine. The outputs are driven directly from these
  // registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_data_reg <= '0;
      out_sel_reg  <= '0;
      ptr_reg      <= SW'(N - 1);
    end else if (grant) begin
      // This covers both cases: loading an empty slot, and draining and
      // refilling a full slot on the same edge.
      state_reg    <= FULL;
      out_data_reg <= chan_data[grant_idx];
      out_sel_reg  <= grant_idx;
      // Only round-robin grants advance the pointer. Fixed-mode traffic
      // leaves the rotation where it was.
      if (mode) begin
        ptr_reg <= grant_idx;
      end
    end else if (slot_free) begin
      state_reg <= EMPTY;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

`ifdef MUX_RR_STATS_EN
  logic [15:0] xfer_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_reg
//
// Bench for mux_rr_reg with WIDTH=8 and N=4.
// The stimulus applies directed vectors. For each grant it expects, it pushes
// the hand-computed output word into a scoreboard queue. A separate monitor
// pops the queue and compares on every out_valid && out_ready transfer.
// Define MUX_RR_STATS_EN to build the transfer counter and exercise it.
// -----------------------------------------------------------------------------
module tb_mux_rr_reg;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SW-1:0]      s;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;
`ifdef MUX_RR_STATS_EN
  logic [15:0]        xfer_cnt;
`endif

  always #5 clk = ~clk;

  mux_rr_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
`ifdef MUX_RR_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel k carries 8'h11 * (k+1): 11, 22, 33, 44.
  task automatic push(input int sel);
    exp_t e;
    e.data = 8'((sel + 1) * 17);
    e.sel  = 2'(sel);
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got sel %0d data %0h expected none",
                 out_sel, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("xfer_data", 32'(out_data), 32'(mon_e.data));
        chk("xfer_sel", 32'(out_sel), 32'(mon_e.sel));
        $display("xfer sel=%0d data=%02h", out_sel, out_data);
      end
    end
  end

  initial begin
    int rr_seq[5];
    int skip_seq[3];
    rr_seq   = '{0, 1, 2, 3, 0};
    skip_seq = '{1, 3, 1};

    rst       = 1'b1;
    in_data   = 32'h44332211;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    mode      = 1'b0;
    s         = 2'd0;

    // Reset state. in_ready must stay low even with all channels valid.
    next();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    next();
    rst = 1'b0;

    // Fixed select: s = 0..3, one cycle each.
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      @(negedge clk);
      chk("fix_in_ready", 32'(in_ready), 32'(1 << k));
      push(k);
      next();
    end
    in_valid = 4'h0;
    @(negedge clk);
    chk("fix_idle_ready", 32'(in_ready), 32'd0);
    next();
    @(negedge clk);
    chk("fix_drained", 32'(out_valid), 32'd0);
    next();

    // Round-robin from reset: 0,1,2,3,0.
    rst = 1'b1;
    next();
    rst      = 1'b0;
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(1 << rr_seq[j]));
      push(rr_seq[j]);
      next();
    end

    // Skip invalid channels: ptr=0, valid 1010 gives 1,3,1.
    in_valid = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("skip_in_ready", 32'(in_ready), 32'(1 << skip_seq[j]));
      push(skip_seq[j]);
      next();
    end
    in_valid = 4'h0;
    @(negedge clk);
    next();
    @(negedge clk);
    chk("skip_drained", 32'(out_valid), 32'd0);
    next();

    // Stall: load 22, hold for 5 cycles while s changes, then release.
    mode     = 1'b0;
    s        = 2'd1;
    in_valid = 4'hF;
    @(negedge clk);
    chk("stall_load_ready", 32'(in_ready), 32'b0010);
    push(1);
    next();
    out_ready = 1'b0;
    s         = 2'd2;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'h22);
      chk("hold_sel", 32'(out_sel), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      next();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(in_ready), 32'b0100);
    push(2);
    next();
    in_valid = 4'h0;
    @(negedge clk);
    next();
    @(negedge clk);
    chk("stall_drained", 32'(out_valid), 32'd0);
    next();

    // Reset while holding 44. The held word is dropped, never transferred.
    s         = 2'd3;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    @(negedge clk);
    chk("mh_load_ready", 32'(in_ready), 32'b1000);
    next();
    @(negedge clk);
    chk("mh_hold_data", 32'(out_data), 32'h44);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("mh_rst_ready", 32'(in_ready), 32'd0);
    next();
    rst      = 1'b0;
    in_valid = 4'h0;
    @(negedge clk);
    chk("mh_out_valid", 32'(out_valid), 32'd0);
    chk("mh_out_data", 32'(out_data), 32'd0);
    next();
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mh_first_rr", 32'(in_ready), 32'b0001);
    push(0);
    next();
    in_valid = 4'h0;
    @(negedge clk);
    next();
    @(negedge clk);
    chk("mh_drained", 32'(out_valid), 32'd0);
    next();

`ifdef MUX_RR_STATS_EN
    // Ten transfers, then three stalled cycles.
    rst = 1'b1;
    next();
    rst       = 1'b0;
    mode      = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      push((j - 1) % 4);
      next();
    end
    in_valid = 4'h0;
    @(negedge clk);
    next();
    in_valid  = 4'hF;
    out_ready = 1'b0;
    @(negedge clk);
    push(2);
    next();
    in_valid = 4'h0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stats_cnt10", 32'(xfer_cnt), 32'd10);
      next();
    end
    out_ready = 1'b1;
    @(negedge clk);
    next();
    @(negedge clk);
    next();

    // Counter wrap: 65535 transfers reach 0xFFFF, and one more wraps to 0.
    rst = 1'b1;
    next();
    rst      = 1'b0;
    in_valid = 4'hF;
    for (int j = 1; j <= 65538; j++) begin
      @(negedge clk);
      if (j == 65537) chk("stats_ffff", 32'(xfer_cnt), 32'hFFFF);
      if (j == 65538) chk("stats_wrap", 32'(xfer_cnt), 32'd0);
      push((j - 1) % 4);
      next();
    end
    in_valid = 4'h0;
    @(negedge clk);
    next();
`endif

    // Give the monitor a bounded window to drain the scoreboard.
    for (int j = 0; j < 5 && sb.size() != 0; j++) begin
      next();
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data bits per channel (1..64).
REQ-002 Parameter N, default 4, SHALL set the channel count (2..16); SW = $clog2(N).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_data  input  N*WIDTH  SHALL carry channel k in bits [k*WIDTH +: WIDTH].
REQ-006 in_valid  input  N  SHALL mark per-channel data valid.
REQ-007 in_ready  output  N  SHALL be a one-hot-or-zero accept strobe per channel.
REQ-008 s  input  SW  SHALL select the channel in fixed mode.
REQ-009 mode  input  1  SHALL choose 0 = fixed select by s, 1 = round-robin.
REQ-010 out_data  output  WIDTH  SHALL hold the registered selected word.
REQ-011 out_valid  output  1  SHALL flag out_data valid.
REQ-012 out_ready  input  1  SHALL indicate downstream accept.
REQ-013 out_sel  output  SW  SHALL give the source channel of the current out_data.

Function
REQ-014 Slot free SHALL be defined as (!out_valid || out_ready); grants occur only when the slot is free.
REQ-015 Fixed mode: grant channel s iff s < N and in_valid[s]; s >= N SHALL grant nothing.
REQ-016 Round-robin mode: grant the first valid channel searching ptr+1, ptr+2, ... wrapping modulo N; ptr SHALL update to the granted index on each grant.
REQ-017 in_ready SHALL be combinational, asserted only for the granted channel in that cycle; zero otherwise.
REQ-018 On a grant, out_data/out_sel SHALL load the granted word/index and out_valid SHALL be 1 on the next edge (latency 1 cycle).
REQ-019 Slot free with no grant SHALL clear out_valid on the next edge.
REQ-020 While out_valid=1 and out_ready=0 (HOLD), out_data, out_sel, out_valid SHALL remain stable and in_ready SHALL be all zero.
REQ-021 out_ready=1 with a simultaneous grant SHALL transfer the old word and load the new one in the same edge (full throughput, one word/cycle).
REQ-022 State machine: EMPTY (out_valid=0) -> FULL on grant; FULL -> FULL on grant while slot free or on stall; FULL -> EMPTY when out_ready=1 and no grant.
REQ-023 mode or s changes SHALL affect only the next grant decision, never held data; ptr SHALL be retained across mode changes.
REQ-024 in_valid deasserting without in_ready SHALL discard nothing and cause no state change.

Reset
REQ-025 rst=1 SHALL set out_valid=0, out_data=0, out_sel=0, ptr=N-1 (first round-robin grant = channel 0).
REQ-026 rst asserted mid-HOLD SHALL drop the held word; in_ready SHALL be all zero during rst.

Configuration
REQ-027 With MUX_RR_STATS_EN defined, output xfer_cnt (16 bits) SHALL count out_valid&&out_ready transfers, wrap 0xFFFF->0, reset to 0.
REQ-028 Without MUX_RR_STATS_EN, xfer_cnt and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, N=4)
REQ-029 Fixed: mode=0, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1, s=0..3 one cycle each -> out_data 11,22,33,44 one cycle later, out_sel 0..3.
REQ-030 Round-robin: mode=1, all valid, out_ready=1 after reset -> out_sel 0,1,2,3,0 on consecutive cycles, in_ready one-hot 0001,0010,0100,1000.
REQ-031 Skip: mode=1, in_valid=4'b1010 -> out_sel alternates 1,3,1; in_ready[0] and in_ready[2] never asserted.
REQ-032 Stall: out_ready=0 for 5 cycles after load of 8'h22 -> out_data stays 22, out_valid=1, in_ready=0000; on release next word appears next cycle.
REQ-033 Reset mid-HOLD: rst=1 for 1 cycle while FULL -> out_valid=0, out_data=0; next round-robin grant is channel 0.
REQ-034 Stats (MUX_RR_STATS_EN): 10 transfers then 3 stalled cycles -> xfer_cnt=10; counter preset to 0xFFFF plus 1 transfer -> 0.
